aes_cipher_core: RTL and testbench
==================================

# aes_cipher_core

Parametrised iterative AES engine that succeeds the fixed-flow round sequencer. It supports 128/192/256-bit keys at elaboration time and encrypt or decrypt per block. Blocks are accepted and returned over a valid/ready handshake, and one full round completes per clock. It sits between the SPI front-end buffer and the key-expansion block, which supplies the flattened round-key schedule.

## Interface
Parameters:
- KEY_BITS, 128, key length (128/192/256).
- NR, derived: 10/12/14 for KEY_BITS 128/192/256. Not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block present.
- in_ready  out  1  core can accept a block.
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled on input handshake.
- in_data  in  [0:127]  plaintext or ciphertext; byte 0 = bits [0:7], column-major state.
- w  in  [0:128*(NR+1)-1]  round keys; key i = w[128*i +: 128]. Must stay stable from accept until the output handshake.
- out_valid  out  1  result held on out_data.
- out_ready  in  1  consumer accepts result.
- out_data  out  [0:127]  cipher/plain result, registered.
- busy  out  1  high in ROUND and DONE.

## Operation
- States: IDLE, ROUND, DONE. Reset state is IDLE.
- Round counter rnd has width 4 and range 1..NR.
- The state register st is 128 bits. The mode register is 1 bit.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch mode.
  - Load st = in_data ^ w key 0 for encrypt, or in_data ^ w key NR for decrypt.
  - Set rnd = 1 and go to ROUND.
- ROUND, encrypt, round r:
  - st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), key r).
  - MixColumns is bypassed when r == NR.
- ROUND, decrypt, round r (FIPS-197 inverse cipher):
  - t = InvSubBytes(InvShiftRows(st)) ^ key (NR-r).
  - st <= InvMixColumns(t) when r < NR, else t.
- ROUND sequencing:
  - If r == NR: load out_data <= next st, set out_valid = 1, go to DONE.
  - Otherwise rnd <= rnd + 1.
- DONE:
  - out_valid = 1 and out_data is held.
  - On out_ready, clear out_valid and go to IDLE.
  - in_ready = 0 in DONE; there is no accept in the same cycle as the release.
- in_valid is ignored outside IDLE. in_data and in_mode may change freely after accept.
- Asynchronous rst in any state returns to IDLE immediately. The in-flight block is discarded and not reported.
- All arithmetic is GF(2^8) byte-wise. There are no carries. rnd never exceeds NR.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_data = 0, st = 0, rnd = 1, state = IDLE.
- Latency: the accept edge is cycle 0. out_valid rises after the edge at cycle NR, giving 10/12/14 cycles.
- Throughput: one block per NR + 2 cycles when out_ready is held high. This covers the accept, NR rounds and the release cycle.
- out_data is stable for the whole time out_valid = 1.
- out_ready may be held low indefinitely. The core stalls in DONE.
- out_ready high while out_valid = 0 has no effect.
- Mode is per block. Back-to-back blocks may alternate modes without restriction.
- The critical path is one combinational round: 4 transforms plus XOR. There is no internal pipelining.

## Structure
- Shared package aes_pkg holds:
  - the nr_of(key_bits) constant function;
  - the state enum (IDLE/ROUND/DONE);
  - MODE_ENC/MODE_DEC constants;
  - the BLOCK_W = 128 constant.
- Reused leaf modules: SubBytes, ShiftRows, MixColumns, AddRoundKey.
- New sub-module aes_inv_round (combinational): InvShiftRows, then InvSubBytes, then key XOR, then InvMixColumns, with a last_round bypass input.
- Round-key select is a mux on w indexed by rnd for encrypt and NR - rnd for decrypt. It lives in the core.

## Test plan
- AES-128 encrypt:
  - Stimulus: FIPS-197 C.1 key 000102…0f, plaintext 00112233445566778899aabbccddeeff.
  - Response: out_data = 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 cycles after accept.
- AES-192 and AES-256 builds, encrypt then decrypt of the result:
  - Response: C.2 gives dda97ca4864cdfe06eaf70a0ec0d7191 in 12 cycles; C.3 gives 8ea2b7ca516745bfeafc49904b496089 in 14 cycles.
  - The decrypt output returns 00112233…eeff.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 20 cycles after out_valid.
  - Response: out_data stays constant, in_ready stays 0, and a new in_valid is ignored.
  - Release: out_ready = 1 for one cycle, then in_ready = 1 on the next cycle.
- Back-to-back mixed modes:
  - Stimulus: in_valid held high with encrypt, decrypt, encrypt blocks.
  - Response: each result is correct and accepts are spaced NR + 2 cycles apart.
- Reset mid-operation:
  - Stimulus: assert rst at round 5, asynchronously between clock edges.
  - Response: out_valid = 0 and in_ready = 1 immediately. The next block encrypts correctly with full latency.
- Input churn:
  - Stimulus: change in_data and in_mode every cycle after accept.
  - Response: the result matches the block latched at accept.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) round transforms.
// State byte k lives at bits [127-8k -: 8]; column-major, row = k % 4.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    typedef logic [BLOCK_W-1:0] block_t;

    function automatic int nr_of(input int key_bits);
        case (key_bits)
            192:     return 12;
            256:     return 14;
            default: return 10;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse; zero maps to zero
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(
        input logic [7:0] a,
        input int         n
    );
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2)
                 ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3)
                  ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] byte_at(
        input block_t s,
        input int     k
    );
        return s[BLOCK_W-1-8*k -: 8];
    endfunction

    function automatic block_t sub_bytes(input block_t s);
        block_t o;
        for (int k = 0; k < 16; k++)
            o[BLOCK_W-1-8*k -: 8] = sbox(byte_at(s, k));
        return o;
    endfunction

    function automatic block_t inv_sub_bytes(input block_t s);
        block_t o;
        for (int k = 0; k < 16; k++)
            o[BLOCK_W-1-8*k -: 8] = inv_sbox(byte_at(s, k));
        return o;
    endfunction

    function automatic block_t shift_rows(input block_t s);
        block_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[BLOCK_W-1-8*(r+4*c) -: 8] =
                    byte_at(s, r + 4 * ((c + r) % 4));
        return o;
    endfunction

    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[BLOCK_W-1-8*(r+4*c) -: 8] =
                    byte_at(s, r + 4 * ((c + 4 - r) % 4));
        return o;
    endfunction

    function automatic block_t mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = byte_at(s, 4 * c);
            a1 = byte_at(s, 4 * c + 1);
            a2 = byte_at(s, 4 * c + 2);
            a3 = byte_at(s, 4 * c + 3);
            o[BLOCK_W-1-32*c -: 32] = {
                xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
            };
        end
        return o;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = byte_at(s, 4 * c);
            a1 = byte_at(s, 4 * c + 1);
            a2 = byte_at(s, 4 * c + 2);
            a3 = byte_at(s, 4 * c + 3);
            o[BLOCK_W-1-32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
            };
        end
        return o;
    endfunction

    function automatic block_t add_round_key(
        input block_t s,
        input block_t k
    );
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational FIPS-197 inverse-cipher round.
// The final round skips InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] st_i,
    input  logic [BLOCK_W-1:0] key_i,
    input  logic               last_i,
    output logic [BLOCK_W-1:0] st_o
);

    block_t t;

    always_comb begin
        t    = add_round_key(inv_sub_bytes(inv_shift_rows(st_i)), key_i);
        st_o = last_i ? t : inv_mix_columns(t);
    end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 engine: one full round per clock,
// per-block encrypt/decrypt, valid/ready on both sides.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_mode,
    input  logic [BLOCK_W-1:0]                     in_data,
    input  logic [BLOCK_W*(nr_of(KEY_BITS)+1)-1:0] w,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [BLOCK_W-1:0]                     out_data,
    output logic                                   busy
);

    localparam int NR = nr_of(KEY_BITS);
    localparam int KW = BLOCK_W * (NR + 1);
    localparam logic [3:0] NR4 = 4'(NR);

    state_e     state_q, state_d;
    block_t     st_q, st_d;
    block_t     out_q, out_d;
    logic [3:0] rnd_q, rnd_d;
    logic       mode_q, mode_d;

    block_t     keys [0:NR];
    block_t     rk;
    block_t     enc_sr, enc_nxt, dec_nxt, round_nxt;
    logic [3:0] key_idx;
    logic       last;

    for (genvar i = 0; i <= NR; i++) begin : g_key
        assign keys[i] = w[KW-1-BLOCK_W*i -: BLOCK_W];
    end

    // Decrypt walks the schedule backwards
    assign key_idx = (mode_q == MODE_DEC) ? NR4 - rnd_q : rnd_q;
    assign rk      = keys[key_idx];
    assign last    = (rnd_q == NR4);

    assign enc_sr  = shift_rows(sub_bytes(st_q));
    assign enc_nxt = add_round_key(last ? enc_sr : mix_columns(enc_sr), rk);

    aes_inv_round u_inv_round (
        .st_i   (st_q),
        .key_i  (rk),
        .last_i (last),
        .st_o   (dec_nxt)
    );

    assign round_nxt = (mode_q == MODE_DEC) ? dec_nxt : enc_nxt;

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        out_d   = out_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    st_d    = in_data ^ ((in_mode == MODE_DEC) ?
                                         keys[NR] : keys[0]);
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d = round_nxt;
                if (last) begin
                    out_d   = round_nxt;
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            out_q   <= '0;
            rnd_q   <= 4'd1;
            mode_q  <= MODE_ENC;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            out_q   <= out_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: 128/192/256-bit builds side by side,
// FIPS-197 vectors plus random blocks against a byte-array model.
module tb_aes_cipher_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [3];
    logic         im   [3];
    logic         ordy [3];
    logic [127:0] idat [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         bz   [3];
    logic [127:0] od   [3];
    logic [1407:0] w0;
    logic [1663:0] w1;
    logic [1919:0] w2;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] rk  [3][15];

    always #5 clk = ~clk;

    aes_cipher_core #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_mode(im[0]), .in_data(idat[0]), .w(w0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .busy(bz[0])
    );

    aes_cipher_core #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_mode(im[1]), .in_data(idat[1]), .w(w1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .busy(bz[1])
    );

    aes_cipher_core #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_mode(im[2]), .in_data(idat[2]), .w(w2),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .busy(bz[2])
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic check1(input string tag, input logic obs,
                          input logic want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int want);
        checks++;
        assert (obs == want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a,
                                      input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from a brute-force inverse search and the bitwise affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic expand(input int k, input logic [255:0] key);
        logic [31:0] wd [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = 4 + 2 * k;
        nr = 10 + 2 * k;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            rk[k][r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
            case (k)
                0:       w0[1407-128*r -: 128] = rk[k][r];
                1:       w1[1663-128*r -: 128] = rk[k][r];
                default: w2[1919-128*r -: 128] = rk[k][r];
            endcase
        end
    endtask

    function automatic logic [127:0] model(input int k, input logic dec,
                                           input logic [127:0] din);
        logic [7:0]   s  [16];
        logic [7:0]   t  [16];
        logic [7:0]   cf [4];
        logic [127:0] key;
        logic [127:0] o;
        int nr;
        int src;
        nr  = 10 + 2 * k;
        key = rk[k][dec ? nr : 0];
        for (int i = 0; i < 16; i++)
            s[i] = din[127-8*i -: 8] ^ key[127-8*i -: 8];
        if (dec) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int rd = 1; rd <= nr; rd++) begin
            key = rk[k][dec ? nr - rd : rd];
            for (int i = 0; i < 16; i++) begin
                if (dec) src = i % 4 + 4 * ((i / 4 - i % 4 + 4) % 4);
                else     src = i % 4 + 4 * ((i / 4 + i % 4) % 4);
                t[i] = dec ? (isb[s[src]] ^ key[127-8*i -: 8]) : sb[s[src]];
            end
            if (rd < nr) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        s[r+4*c] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[r+4*c] = s[r+4*c]
                                     ^ gm(cf[(j-r+4)%4], t[j+4*c]);
                    end
            end else begin
                s = t;
            end
            if (!dec)
                for (int i = 0; i < 16; i++)
                    s[i] = s[i] ^ key[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Accept one block, churn the inputs while it runs, wait for the result
    task automatic run_block(input int k, input logic dec,
                             input logic [127:0] din,
                             output logic [127:0] res, output int lat);
        @(negedge clk);
        check1($sformatf("ready_pre%0d", k), ir[k], 1'b1);
        iv[k]   = 1'b1;
        im[k]   = dec;
        idat[k] = din;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        lat   = 0;
        while (!ov[k] && lat < 40) begin
            idat[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
            im[k]   = 1'($urandom());
            @(posedge clk);
            #1;
            lat++;
        end
        res = od[k];
        if (ordy[k]) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [255:0] fk [3];
        logic [127:0] fc [3];
        logic [127:0] pt, res, res2, held;
        logic [255:0] key;
        logic [127:0] bd [3];
        logic [127:0] be [3];
        logic [127:0] br [3];
        logic         bm [3];
        int           at [3];
        int           lat, j, got, cyc;
        logic         acc, dec;

        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; im[k] = 1'b0; idat[k] = '0; ordy[k] = 1'b1;
            at[k] = 0; br[k] = '0;
        end
        w0 = '0; w1 = '0; w2 = '0;
        build_sbox();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check1($sformatf("rst_ready%0d", k), ir[k], 1'b1);
            check1($sformatf("rst_valid%0d", k), ov[k], 1'b0);
            check1($sformatf("rst_busy%0d", k), bz[k], 1'b0);
            check($sformatf("rst_data%0d", k), od[k], 128'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        pt    = 128'h00112233445566778899aabbccddeeff;
        fk[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        fk[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                 64'h0};
        fk[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        fc[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        fc[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        fc[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int k = 0; k < 3; k++) begin
            expand(k, fk[k]);
            run_block(k, 1'b0, pt, res, lat);
            check($sformatf("fips_enc%0d", k), res, fc[k]);
            checki($sformatf("fips_enc_lat%0d", k), lat, 10 + 2 * k);
            run_block(k, 1'b1, res, res2, lat);
            check($sformatf("fips_dec%0d", k), res2, pt);
            checki($sformatf("fips_dec_lat%0d", k), lat, 10 + 2 * k);
        end

        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 4; n++) begin
                key = {rnd128(), rnd128()};
                expand(k, key);
                pt  = rnd128();
                dec = 1'($urandom());
                run_block(k, dec, pt, res, lat);
                check($sformatf("rand%0d_%0d", k, n), res, model(k, dec, pt));
                checki($sformatf("rand_lat%0d_%0d", k, n), lat, 10 + 2 * k);
            end

        ordy[0] = 1'b0;
        pt = rnd128();
        run_block(0, 1'b0, pt, held, lat);
        check("bp_result", held, model(0, 1'b0, pt));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            iv[0]   = 1'b1;
            im[0]   = 1'($urandom());
            idat[0] = rnd128();
            @(posedge clk);
            #1;
            check($sformatf("bp_data%0d", i), od[0], held);
            check1($sformatf("bp_valid%0d", i), ov[0], 1'b1);
            check1($sformatf("bp_ready%0d", i), ir[0], 1'b0);
        end
        @(negedge clk);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check1("bp_rel_valid", ov[0], 1'b0);
        check1("bp_rel_ready", ir[0], 1'b1);
        check1("bp_rel_busy", bz[0], 1'b0);

        bd[0] = rnd128();
        bm[0] = 1'b0;
        bd[1] = model(1, 1'b0, bd[0]);
        bm[1] = 1'b1;
        bd[2] = rnd128();
        bm[2] = 1'b0;
        for (int n = 0; n < 3; n++) be[n] = model(1, bm[n], bd[n]);
        j = 0; got = 0; cyc = 0;
        while (got < 3 && cyc < 100) begin
            @(negedge clk);
            if (j < 3) begin
                iv[1] = 1'b1; im[1] = bm[j]; idat[1] = bd[j];
            end else begin
                iv[1] = 1'b0;
            end
            acc = iv[1] && ir[1];
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                at[j] = cyc;
                j++;
            end
            if (ov[1]) begin
                br[got] = od[1];
                got++;
            end
        end
        iv[1] = 1'b0;
        checki("b2b_count", got, 3);
        for (int n = 0; n < 3; n++)
            check($sformatf("b2b_res%0d", n), br[n], be[n]);
        check("b2b_roundtrip", br[1], bd[0]);
        checki("b2b_gap01", at[1] - at[0], 14);
        checki("b2b_gap12", at[2] - at[1], 14);

        pt = rnd128();
        @(negedge clk);
        iv[2] = 1'b1; im[2] = 1'b0; idat[2] = pt;
        @(posedge clk);
        #1;
        iv[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check1("mid_busy", bz[2], 1'b1);
        check1("mid_ready", ir[2], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check1("arst_valid", ov[2], 1'b0);
        check1("arst_ready", ir[2], 1'b1);
        check1("arst_busy", bz[2], 1'b0);
        check("arst_data", od[2], 128'h0);
        @(negedge clk);
        rst = 1'b0;
        run_block(2, 1'b0, pt, res, lat);
        check("post_rst_res", res, model(2, 1'b0, pt));
        checki("post_rst_lat", lat, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
